// File: rtl/seven_seg_scan_driver_if.sv
// Display-side bundle for the seven-segment scan driver: value/control from the
// datapath and the multiplexed segment/anode pins back out.
interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    hex_mode;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output value, dp_in, load, hex_mode, blank_lz,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  value, dp_in, load, hex_mode, blank_lz,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: prescaled digit scan, BCD/hex decode,
// leading-zero blanking, anode dead time and frame-aligned double buffering.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int DEAD_CYCLES    = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    seven_seg_scan_driver_if.slave bus
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      DEAD_END = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        // In BCD mode anything above 9 is a data error; show a lone dash.
        if (!hex && nib > 4'd9) s = 7'h40;
        return s;
    endfunction

    logic [CNT_W-1:0]      presc;
    logic [IDX_W-1:0]      idx;
    logic                  tick;
    logic                  frame_edge;
    logic [VAL_W-1:0]      pend_val;
    logic [VAL_W-1:0]      act_val;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [NUM_DIGITS-1:0] act_dp;
    logic                  pend_flag;
    logic [NUM_DIGITS-1:0] zero_tail;
    logic [3:0]            cur_nib;
    logic                  blank;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] an_raw;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;

    assign tick       = (presc == CNT_LAST);
    assign frame_edge = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Active only changes on the frame edge, so a scan never mixes two values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val  <= '0;
            pend_dp   <= '0;
            act_val   <= '0;
            act_dp    <= '0;
            pend_flag <= 1'b0;
        end else if (frame_edge) begin
            if (bus.load) begin
                act_val <= bus.value;
                act_dp  <= bus.dp_in;
            end else if (pend_flag) begin
                act_val <= pend_val;
                act_dp  <= pend_dp;
            end
            pend_flag <= 1'b0;
        end else if (bus.load) begin
            pend_val  <= bus.value;
            pend_dp   <= bus.dp_in;
            pend_flag <= 1'b1;
        end
    end

    // zero_tail[k] is set when nibble k and every nibble above it are zero.
    always_comb begin
        zero_tail = '0;
        zero_tail[NUM_DIGITS-1] = (act_val[VAL_W-1 -: 4] == 4'h0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            zero_tail[k] = (act_val[4*k +: 4] == 4'h0) && zero_tail[k+1];
        end
    end

    always_comb begin
        cur_nib = act_val[{idx, 2'b00} +: 4];
        blank   = bus.blank_lz && (idx != '0) && zero_tail[idx];
        seg_raw = blank ? 7'h00 : decode(cur_nib, bus.hex_mode);
        an_raw  = (presc < DEAD_END) ? '0 : (NUM_DIGITS'(1) << idx);
    end

    // Output stage: one register between the scan state and the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_raw ^ SEG_OFF;
            dp_q  <= act_dp[idx] ^ DP_OFF;
            an_q  <= an_raw ^ AN_OFF;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_edge;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomised bench for seven_seg_scan_driver with a cycle-level behavioural
// model of the scan schedule, frame-aligned loads and decode/blanking rules.
module tb_seven_seg_scan_driver;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scan_driver #(
        .NUM_DIGITS    (N),
        .REFRESH_DIV   (4),
        .DEAD_CYCLES   (1),
        .SEG_ACTIVE_LOW(0),
        .AN_ACTIVE_LOW (0)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: clocks since reset release plus the two display buffers.
    int unsigned cyc;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_flag;
    bit          g_hx, g_blz;
    int          fd_count;
    logic [6:0]  seen_seg [N];
    logic [3:0]  seen_dp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] act, input int d,
                                           input bit hx, input bit blz);
        logic [3:0] nib;
        nib = 4'(act >> (4 * d));
        if (blz && d != 0 && (act >> (4 * d)) == 16'd0) return 7'h00;
        if (!hx && nib > 4'd9) return 7'h40;
        return font[nib];
    endfunction

    task automatic model_reset();
        cyc = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_flag = 0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d);
        int slot, phase;
        bit boundary;
        logic [6:0] e_seg;
        logic e_dp;
        logic [3:0] e_an;
        bus.load = ld; bus.value = v; bus.dp_in = d;
        bus.hex_mode = g_hx; bus.blank_lz = g_blz;
        #1;
        slot     = int'((cyc / 4) % 4);
        phase    = int'(cyc % 4);
        boundary = ((cyc % 16) == 15);
        check("frame_done", {31'd0, bus.frame_done}, {31'd0, boundary});
        if (bus.frame_done) fd_count++;
        e_seg = exp_seg(m_act, slot, g_hx, g_blz);
        e_dp  = m_act_dp[slot];
        e_an  = (phase < 1) ? 4'b0000 : 4'(1 << slot);
        @(posedge clk);
        if (boundary) begin
            if (ld) begin m_act = v; m_act_dp = d; end
            else if (m_flag) begin m_act = m_pend; m_act_dp = m_pend_dp; end
            m_flag = 0;
        end else if (ld) begin
            m_pend = v; m_pend_dp = d; m_flag = 1;
        end
        cyc++;
        #1;
        check("seg", {25'd0, bus.seg}, {25'd0, e_seg});
        check("dp", {31'd0, bus.dp}, {31'd0, e_dp});
        check("an", {28'd0, bus.an}, {28'd0, e_an});
        for (int k = 0; k < N; k++) begin
            if (bus.an == 4'(1 << k)) begin
                seen_seg[k] = bus.seg;
                seen_dp[k]  = bus.dp;
            end
        end
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic run_to(input int unsigned ph);
        while ((cyc % 16) != ph) step(1'b0, 16'h0, 4'h0);
    endtask

    // One full frame starting at slot 0, with up to two loads at given offsets.
    task automatic capture_frame(input int la, input logic [15:0] va,
                                 input int lb, input logic [15:0] vb);
        for (int k = 0; k < N; k++) seen_seg[k] = 7'h55;
        seen_dp = 4'hA;
        for (int i = 0; i < 16; i++) begin
            if (i == la)      step(1'b1, va, 4'h0);
            else if (i == lb) step(1'b1, vb, 4'h0);
            else              step(1'b0, 16'h0, 4'h0);
        end
    endtask

    task automatic check_digits(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0);
        check({tag, "_d0"}, {25'd0, seen_seg[0]}, {25'd0, s0});
        check({tag, "_d1"}, {25'd0, seen_seg[1]}, {25'd0, s1});
        check({tag, "_d2"}, {25'd0, seen_seg[2]}, {25'd0, s2});
        check({tag, "_d3"}, {25'd0, seen_seg[3]}, {25'd0, s3});
    endtask

    initial begin
        bool_init();
    end

    task automatic bool_init();
        bit found;
        logic [15:0] v;
        bus.load = 0; bus.value = '0; bus.dp_in = '0; bus.hex_mode = 0; bus.blank_lz = 0;
        g_hx = 0; g_blz = 0;
        model_reset();

        // Reset and idle scan
        #12;
        check("rst_an", {28'd0, bus.an}, 32'd0);
        check("rst_seg", {25'd0, bus.seg}, 32'd0);
        check("rst_dp", {31'd0, bus.dp}, 32'd0);
        check("rst_fd", {31'd0, bus.frame_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fd_count = 0;
        for (int i = 0; i < 32; i++) step(1'b0, 16'h0, 4'h0);
        check("idle_fd_count", fd_count, 32'd2);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_digits("idle", 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);

        // BCD sweep
        step(1'b1, 16'h9876, 4'h0);
        run_to(0);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_digits("bcd", 7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101);
        step(1'b1, 16'h000A, 4'h0);
        run_to(0);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check("bcd_err_d0", {25'd0, seen_seg[0]}, {25'd0, 7'b1000000});

        // Hex decode with decimal points
        g_hx = 1;
        step(1'b1, 16'hFEDC, 4'b0101);
        run_to(0);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_digits("hex", 7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001);
        check("hex_dp", {28'd0, seen_dp}, 32'b0101);

        // Leading-zero blanking
        g_hx = 0; g_blz = 1;
        step(1'b1, 16'h0040, 4'h0);
        run_to(0);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_digits("lz", 7'b0000000, 7'b0000000, 7'b1100110, 7'b0111111);
        step(1'b1, 16'h0000, 4'h0);
        run_to(0);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_digits("lz0", 7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111);

        // Tear-free loading: two loads mid-frame, then one on the frame edge
        g_blz = 0;
        capture_frame(3, 16'h1111, 8, 16'h2222);
        check_digits("tear_old", 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_digits("tear_new", 7'b1011011, 7'b1011011, 7'b1011011, 7'b1011011);
        run_to(15);
        step(1'b1, 16'h3333, 4'h0);
        capture_frame(-1, 16'h0, -1, 16'h0);
        check_digits("coinc", 7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            g_hx  = 1'($urandom);
            g_blz = 1'($urandom);
            v = 16'($urandom);
            case ($urandom % 3)
                1: v &= 16'h00FF;
                2: v &= 16'h000F;
                default: ;
            endcase
            step(($urandom % 8) == 0, v, 4'($urandom));
        end

        // Asynchronous reset in the middle of a scan
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (bus.an == 4'b0100) found = 1;
            else step(1'b0, 16'h0, 4'h0);
        end
        check("wait_an_0100", {31'd0, found}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_an", {28'd0, bus.an}, 32'd0);
        check("async_seg", {25'd0, bus.seg}, 32'd0);
        check("async_dp", {31'd0, bus.dp}, 32'd0);
        check("async_fd", {31'd0, bus.frame_done}, 32'd0);
        model_reset();
        g_hx = 0; g_blz = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 16'h0, 4'h0);
        step(1'b0, 16'h0, 4'h0);
        check("resume_an", {28'd0, bus.an}, 32'b0001);
        check("resume_seg", {25'd0, bus.seg}, {25'd0, 7'b0111111});
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask
endmodule
